// File: rtl/cdb_arbiter.sv
// Common data bus producer: per-source result FIFOs feeding a round-robin
// arbiter that broadcasts one registered result per cycle to ROB and RS.
package cdb_pkg;
  typedef struct packed {
    logic [5:0]  rob_entry;
    logic [31:0] rd_data;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [1:0]  mem_size;
  } cdb_t;
endpackage

module cdb_src_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  cdb_pkg::cdb_t              wdata,
  output cdb_pkg::cdb_t              rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  cdb_pkg::cdb_t mem_q [DEPTH];
  cdb_pkg::cdb_t mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign count = cnt_q;
  assign ready = (cnt_q != CW'(DEPTH));
endmodule

module cdb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic          [NUM_SRC-1:0]        src_valid,
  input  cdb_pkg::cdb_t [NUM_SRC-1:0]        src_data,
  output logic          [NUM_SRC-1:0]        src_ready,
  output cdb_pkg::cdb_t                      cdb,
  output logic                               cdb_en,
  output logic          [NUM_SRC-1:0]        src_granted
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int RW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic          [NUM_SRC-1:0][CW-1:0] cnt;
  cdb_pkg::cdb_t [NUM_SRC-1:0]         head;
  logic          [NUM_SRC-1:0]         nonempty, pop;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (src_valid[g] & src_ready[g]),
      .pop   (pop[g]),
      .wdata (src_data[g]),
      .rdata (head[g]),
      .count (cnt[g]),
      .ready (src_ready[g])
    );
    assign nonempty[g] = (cnt[g] != '0);
  end

  logic [RW-1:0]      rr_ptr_q, rr_ptr_d, win;
  logic [RW:0]        cand;
  logic               found;
  cdb_pkg::cdb_t      cdb_q, cdb_d;
  logic               cdb_en_q, cdb_en_d;
  logic [NUM_SRC-1:0] gnt_q, gnt_d;

  // Search starts at rr_ptr and wraps; only pre-edge FIFO counts are seen.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, rr_ptr_q} + (RW+1)'(k);
      if (cand >= (RW+1)'(NUM_SRC)) cand = cand - (RW+1)'(NUM_SRC);
      if (!found && nonempty[cand[RW-1:0]]) begin
        found = 1'b1;
        win   = cand[RW-1:0];
      end
    end
  end

  always_comb begin
    pop      = '0;
    rr_ptr_d = rr_ptr_q;
    cdb_d    = cdb_q;
    cdb_en_d = found;
    gnt_d    = '0;
    if (found) begin
      pop[win] = 1'b1;
      gnt_d    = NUM_SRC'(1) << win;
      cdb_d    = head[win];
      rr_ptr_d = (win == RW'(NUM_SRC - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      cdb_q    <= '0;
      cdb_en_q <= 1'b0;
      gnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
      cdb_en_q <= cdb_en_d;
      gnt_q    <= gnt_d;
    end
  end

  assign cdb         = cdb_q;
  assign cdb_en      = cdb_en_q;
  assign src_granted = gnt_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboarded bench for cdb_arbiter: directed stimulus, a negedge monitor
// pops per-source expected queues whenever a broadcast appears.
module tb_cdb_arbiter;
  import cdb_pkg::*;
  localparam int N = 4;
  localparam int D = 2;

  logic                 clk, rst;
  logic [N-1:0]         src_valid, src_ready, src_granted;
  cdb_t [N-1:0]         src_data;
  cdb_t                 cdb;
  logic                 cdb_en;

  cdb_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .cdb(cdb), .cdb_en(cdb_en), .src_granted(src_granted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vecs = 0;
  int   errs = 0;
  cdb_t exp_q [N][$];
  int   log_q [$];
  int   cyc = 0;
  int   last0 = -100;
  bit   bp_phase = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic cdb_t mk(input int rob, input logic [31:0] rd);
    cdb_t c;
    c.rob_entry = 6'(rob);
    c.rd_data   = rd;
    c.rs1_data  = rd ^ 32'h1111_1111;
    c.rs2_data  = ~rd;
    c.mem_addr  = {rd[15:0], rd[31:16]};
    c.mem_we    = rd[0];
    c.mem_size  = rd[2:1];
    return c;
  endfunction

  // Monitor: consume the broadcast of the last edge, check ready against the
  // model occupancy, then record transfers that the coming edge will take.
  always @(negedge clk) begin
    if (!rst) begin
      if (cdb_en) begin
        int w;
        w = -1;
        for (int i = 0; i < N; i++) if (src_granted[i]) w = i;
        chk("grant_onehot", 256'($onehot(src_granted)), 256'(1));
        if (w >= 0) begin
          if (exp_q[w].size() == 0) begin
            chk("stale_bcast", 256'(cdb.rob_entry), 256'hFFFF);
          end else begin
            cdb_t e;
            e = exp_q[w].pop_front();
            chk("cdb_payload", 256'(cdb), 256'(e));
          end
          log_q.push_back(int'(cdb.rob_entry));
          if (bp_phase && w == 0) begin
            chk("src0_gap_ge4", 256'(cyc - last0 >= 4), 256'(1));
            last0 = cyc;
          end
        end
      end else begin
        chk("gnt_idle", 256'(src_granted), 256'(0));
      end
      for (int i = 0; i < N; i++)
        chk("src_ready", 256'(src_ready[i]), 256'(exp_q[i].size() != D));
      for (int i = 0; i < N; i++)
        if (src_valid[i] && src_ready[i]) exp_q[i].push_back(src_data[i]);
      cyc++;
    end
  end

  task automatic hard_reset();
    @(posedge clk); #2;
    src_valid = '0;
    rst = 1'b1;
    for (int i = 0; i < N; i++) exp_q[i].delete();
    log_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  logic [N-1:0] took;
  int           seq [N];
  bit           saw_full0;
  logic [9:0]   pat;
  bit           rdy2;

  initial begin
    rst = 1'b1; src_valid = '0; src_data = '0;
    #1;
    chk("rst_cdb_en", 256'(cdb_en), 256'(0));
    chk("rst_gnt", 256'(src_granted), 256'(0));
    chk("rst_ready", 256'(src_ready), 256'(4'b1111));
    @(posedge clk); #2 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_en", 256'(cdb_en), 256'(0));
      chk("idle_ready", 256'(src_ready), 256'(4'b1111));
    end

    // single result, two-edge latency
    @(posedge clk); #1;
    src_valid = 4'b0010; src_data[1] = mk(5, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    src_valid = '0;
    @(negedge clk);
    chk("single_early", 256'(cdb_en), 256'(0));
    @(negedge clk);
    chk("single_en", 256'(cdb_en), 256'(1));
    chk("single_gnt", 256'(src_granted), 256'(4'b0010));
    chk("single_rob", 256'(cdb.rob_entry), 256'(5));
    chk("single_rd", 256'(cdb.rd_data), 256'(32'hDEAD_BEEF));
    @(negedge clk);
    chk("single_late", 256'(cdb_en), 256'(0));

    // round-robin from reset pointer
    hard_reset();
    @(posedge clk); #1;
    src_valid = 4'b1111;
    for (int i = 0; i < N; i++) src_data[i] = mk(10 + i, 32'hA000 + i);
    @(posedge clk); #1;
    src_valid = '0;
    log_q.delete();
    repeat (6) @(negedge clk);
    chk("rr_count", 256'(log_q.size()), 256'(4));
    for (int k = 0; k < 4; k++)
      if (k < log_q.size()) chk("rr_order", 256'(log_q[k]), 256'(10 + k));
    chk("rr_idle", 256'(cdb_en), 256'(0));
    @(posedge clk); #1;
    src_valid = 4'b1001; src_data[0] = mk(20, 32'h20); src_data[3] = mk(23, 32'h23);
    @(posedge clk); #1;
    src_valid = '0;
    log_q.delete();
    repeat (4) @(negedge clk);
    chk("rr_wrap_n", 256'(log_q.size()), 256'(2));
    if (log_q.size() == 2) begin
      chk("rr_wrap0", 256'(log_q[0]), 256'(20));
      chk("rr_wrap1", 256'(log_q[1]), 256'(23));
    end

    // back-pressure with all sources streaming
    hard_reset();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0;
      src_data[i] = mk(i * 16, 32'h100 * i);
    end
    src_valid = 4'b1111;
    bp_phase = 1; last0 = -100; saw_full0 = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      took = src_valid & src_ready;
      if (!src_ready[0]) saw_full0 = 1;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        if (took[i]) begin
          seq[i]++;
          src_data[i] = mk(i * 16 + seq[i], 32'h100 * i + seq[i]);
        end
    end
    src_valid = '0;
    bp_phase = 0;
    chk("bp_full0", 256'(saw_full0), 256'(1));
    repeat (12) @(negedge clk);
    for (int i = 0; i < N; i++) chk("bp_drained", 256'(exp_q[i].size()), 256'(0));

    // full-rate single source
    hard_reset();
    @(posedge clk); #1;
    src_valid = 4'b0100; src_data[2] = mk(0, 32'h0);
    rdy2 = 1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (c < 7) src_data[2] = mk(c + 1, 32'(c + 1));
      else if (c == 7) src_valid = '0;
      @(negedge clk);
      pat[c] = cdb_en;
      rdy2 &= src_ready[2];
    end
    chk("stream_pattern", 256'(pat), 256'(10'b01_1111_1110));
    chk("stream_ready2", 256'(rdy2), 256'(1));

    // asynchronous reset mid-stream
    hard_reset();
    @(posedge clk); #1;
    src_valid = 4'b0011; src_data[0] = mk(40, 32'h40); src_data[1] = mk(48, 32'h48);
    @(posedge clk); #1;
    src_data[0] = mk(41, 32'h41); src_data[1] = mk(49, 32'h49);
    @(posedge clk); #1;
    chk("mid_busy", 256'(cdb_en), 256'(1));
    src_valid = '0;
    #1 rst = 1'b1;
    for (int i = 0; i < N; i++) exp_q[i].delete();
    #1;
    chk("mid_en_drop", 256'(cdb_en), 256'(0));
    chk("mid_gnt_drop", 256'(src_granted), 256'(0));
    chk("mid_ready", 256'(src_ready), 256'(4'b1111));
    @(posedge clk); #2 rst = 1'b0;
    log_q.delete();
    repeat (10) @(negedge clk);
    chk("mid_no_stale", 256'(log_q.size()), 256'(0));
    chk("mid_ready_post", 256'(src_ready), 256'(4'b1111));

    for (int i = 0; i < N; i++) chk("final_empty", 256'(exp_q[i].size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
